// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment display path: segment ordering and
// the active-high hex glyph table used by the nibble decoder.
package seg7_pkg;

  // Segment bit positions inside a pattern; seg[0] is segment a.
  typedef enum int unsigned {
    SEG_A = 0,
    SEG_B = 1,
    SEG_C = 2,
    SEG_D = 3,
    SEG_E = 4,
    SEG_F = 5,
    SEG_G = 6
  } seg_idx_t;

  // Pattern written left to right as a b c d e f g, 1 = segment lit.
  typedef logic [0:6] seg_pattern_t;

  // Glyphs 0-9, A, b, C, d, E, F.
  localparam seg_pattern_t HEX_SEG_TABLE [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-high seven-segment pattern.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0]   nibble,
  output seg_pattern_t pattern
);

  assign pattern = HEX_SEG_TABLE[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed hex seven-segment driver. The display word is double-buffered
// and only swapped at the frame wrap so a frame never mixes old and new data.
// Per-digit dp, leading-zero blanking, PWM dimming and blink are applied
// before a single registered output stage.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 8,
  parameter int REFRESH_COUNT  = 100_000,
  parameter int BRIGHT_BITS    = 4,
  parameter int BLINK_COUNT    = 50_000_000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                      clk_100MHz,
  input  logic                      reset_n,
  input  logic                      dm_write,
  input  logic [4*NUM_DIGITS-1:0]   data_in,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic                      blank_lz,
  input  logic [BRIGHT_BITS-1:0]    brightness,
  input  logic [NUM_DIGITS-1:0]     blink_mask,
  output logic [0:6]                seg,
  output logic                      dp,
  output logic [NUM_DIGITS-1:0]     digit,
  output logic                      frame_done
);

  localparam int SEL_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int TMR_W = (REFRESH_COUNT > 1) ? $clog2(REFRESH_COUNT) : 1;
  localparam int BLK_W = (BLINK_COUNT > 1) ? $clog2(BLINK_COUNT) : 1;

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(REFRESH_COUNT - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_COUNT - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_DIGITS - 1);

  // Inactive levels; XOR with an active-high value gives the pin level.
  localparam seg_pattern_t              SEG_INV = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                      DP_INV  = (SEG_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0]     AN_INV  = (AN_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [NUM_DIGITS-1:0]     AN_ONE  = NUM_DIGITS'(1);

  logic [4*NUM_DIGITS-1:0] pending_word;
  logic [NUM_DIGITS-1:0]   pending_dp;
  logic                    pending_valid;
  logic [4*NUM_DIGITS-1:0] disp_word;
  logic [NUM_DIGITS-1:0]   disp_dp;

  logic [TMR_W-1:0]        digit_timer;
  logic [SEL_W-1:0]        digit_sel;
  logic [BRIGHT_BITS-1:0]  pwm_cnt;
  logic [BLK_W-1:0]        blink_cnt;
  logic                    blink_phase;

  logic                    slot_end;
  logic                    frame_wrap;

  logic [3:0]              cur_nibble;
  logic                    cur_dp;
  logic                    cur_blink;
  logic                    lz_keep;
  logic                    lz_blank;
  logic                    lit;
  seg_pattern_t            cur_pattern;

  seg_pattern_t            seg_p1;
  logic                    dp_p1;
  logic [NUM_DIGITS-1:0]   digit_p1;
  logic                    frame_done_p1;

  assign slot_end   = (digit_timer == TMR_LAST);
  assign frame_wrap = slot_end && (digit_sel == SEL_LAST);

  // Digit slot timer and digit selector.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      digit_timer <= '0;
      digit_sel   <= '0;
    end else if (slot_end) begin
      digit_timer <= '0;
      digit_sel   <= (digit_sel == SEL_LAST) ? '0 : digit_sel + 1'b1;
    end else begin
      digit_timer <= digit_timer + 1'b1;
    end
  end

  // Double buffer: writes land in pending, pending moves to displayed on wrap.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      pending_word  <= '0;
      pending_dp    <= '0;
      pending_valid <= 1'b0;
      disp_word     <= '0;
      disp_dp       <= '0;
    end else begin
      if (frame_wrap && pending_valid) begin
        disp_word <= pending_word;
        disp_dp   <= pending_dp;
      end
      if (dm_write) begin
        pending_word  <= data_in;
        pending_dp    <= dp_in;
        pending_valid <= 1'b1;
      end else if (frame_wrap) begin
        pending_valid <= 1'b0;
      end
    end
  end

  // Free-running PWM sub-counter and blink phase generator.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      pwm_cnt     <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (blink_cnt == BLK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // Select the current digit's data and decide whether it may light.
  always_comb begin
    cur_nibble = '0;
    cur_dp     = 1'b0;
    cur_blink  = 1'b0;
    lz_keep    = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_sel == SEL_W'(i)) begin
        cur_nibble = disp_word[4*i +: 4];
        cur_dp     = disp_dp[i];
        cur_blink  = blink_mask[i];
      end
      // A nonzero nibble or a dp at or left of this digit makes it significant.
      if ((i >= int'(digit_sel)) && ((disp_word[4*i +: 4] != 4'h0) || disp_dp[i])) begin
        lz_keep = 1'b1;
      end
    end
    lz_blank = blank_lz && (digit_sel != '0) && !lz_keep;
    lit      = (pwm_cnt <= brightness) && !lz_blank && !(blink_phase && cur_blink);
  end

  seg7_hex_decode u_decode (
    .nibble  (cur_nibble),
    .pattern (cur_pattern)
  );

  // Output register stage: one anode at most, polarity applied here.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      seg_p1        <= SEG_INV;
      dp_p1         <= DP_INV;
      digit_p1      <= AN_INV;
      frame_done_p1 <= 1'b0;
    end else begin
      frame_done_p1 <= frame_wrap;
      if (lit) begin
        seg_p1   <= cur_pattern ^ SEG_INV;
        dp_p1    <= cur_dp ^ DP_INV;
        digit_p1 <= (AN_ONE << digit_sel) ^ AN_INV;
      end else begin
        seg_p1   <= SEG_INV;
        dp_p1    <= DP_INV;
        digit_p1 <= AN_INV;
      end
    end
  end

  assign seg        = seg_p1;
  assign dp         = dp_p1;
  assign digit      = digit_p1;
  assign frame_done = frame_done_p1;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver with 4 digits, 32-cycle slots, 4-bit PWM and a
// 256-cycle blink phase, active-low outputs.
module tb_seg7_scan_driver;

  localparam int N  = 4;
  localparam int R  = 32;
  localparam int BB = 4;
  localparam int BL = 256;

  logic          clk_100MHz = 1'b0;
  logic          reset_n;
  logic          dm_write;
  logic [15:0]   data_in;
  logic [3:0]    dp_in;
  logic          blank_lz;
  logic [3:0]    brightness;
  logic [3:0]    blink_mask;
  logic [0:6]    seg;
  logic          dp;
  logic [3:0]    digit;
  logic          frame_done;

  int total = 0;
  int bad   = 0;

  seg7_scan_driver #(
    .NUM_DIGITS     (N),
    .REFRESH_COUNT  (R),
    .BRIGHT_BITS    (BB),
    .BLINK_COUNT    (BL),
    .SEG_ACTIVE_LOW (1),
    .AN_ACTIVE_LOW  (1)
  ) dut (
    .clk_100MHz (clk_100MHz),
    .reset_n    (reset_n),
    .dm_write   (dm_write),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .blank_lz   (blank_lz),
    .brightness (brightness),
    .blink_mask (blink_mask),
    .seg        (seg),
    .dp         (dp),
    .digit      (digit),
    .frame_done (frame_done)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Active-low glyphs of the hex digits.
  function automatic logic [0:6] glyph(input int v);
    case (v)
      0:  return 7'b0000001;  1:  return 7'b1001111;
      2:  return 7'b0010010;  3:  return 7'b0000110;
      4:  return 7'b1001100;  5:  return 7'b0100100;
      6:  return 7'b0100000;  7:  return 7'b0001111;
      8:  return 7'b0000000;  9:  return 7'b0000100;
      10: return 7'b0001000;  11: return 7'b1100000;
      12: return 7'b0110001;  13: return 7'b1000010;
      14: return 7'b0110000;  default: return 7'b0111000;
    endcase
  endfunction

  // Reference model: everything is derived from the cycle count n since reset.
  int          m_n;
  logic [15:0] m_disp, m_pend;
  logic [3:0]  m_disp_dp, m_pend_dp;
  logic        m_pv;
  logic [0:6]  e_seg = 7'h7F;
  logic        e_dp = 1'b1;
  logic [3:0]  e_digit = 4'hF;
  logic        e_fd = 1'b0;

  always @(posedge clk_100MHz) begin
    int  slot, pwm, phase, nib;
    bit  sig, off;
    if (!reset_n) begin
      m_n = 0; m_disp = '0; m_disp_dp = '0; m_pend = '0; m_pend_dp = '0; m_pv = 1'b0;
      e_seg = 7'h7F; e_dp = 1'b1; e_digit = 4'hF; e_fd = 1'b0;
    end else begin
      slot  = (m_n / R) % N;
      pwm   = m_n % (1 << BB);
      phase = (m_n / BL) % 2;
      nib   = int'((m_disp >> (4 * slot)) & 16'h000F);
      sig   = ((m_disp >> (4 * slot)) != 0) || ((m_disp_dp >> slot) != 0);
      off   = (pwm > int'(brightness)) || (blank_lz && slot != 0 && !sig) ||
              (phase == 1 && blink_mask[slot]);
      if (off) begin
        e_seg = 7'h7F; e_dp = 1'b1; e_digit = 4'hF;
      end else begin
        e_seg = glyph(nib); e_dp = ~m_disp_dp[slot]; e_digit = ~(4'b0001 << slot);
      end
      e_fd = (m_n % (R * N)) == (R * N - 1);
      if (e_fd && m_pv) begin
        m_disp = m_pend; m_disp_dp = m_pend_dp; m_pv = 1'b0;
      end
      if (dm_write) begin
        m_pend = data_in; m_pend_dp = dp_in; m_pv = 1'b1;
      end
      m_n++;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk_100MHz) begin
    if (!reset_n)
      check("cycle_reset", {25'd0, seg, dp, digit, frame_done}, {25'd0, 7'h7F, 1'b1, 4'hF, 1'b0});
    else
      check("cycle", {25'd0, seg, dp, digit, frame_done}, {25'd0, e_seg, e_dp, e_digit, e_fd});
    if ($countones(~digit) > 1) begin
      total++; bad++;
      $display("FAIL anode_onehot at %0t: got %b expected at most one low", $time, digit);
    end
  end

  task automatic step();
    @(posedge clk_100MHz); #3;
  endtask

  task automatic wait_fd(output int cyc);
    cyc = 0;
    do begin step(); cyc++; end while (!frame_done && cyc < 400);
    if (!frame_done) check("wait_frame_done_timeout", 32'(cyc), 32'd0);
  endtask

  task automatic wait_digit(input logic [3:0] d);
    int cyc = 0;
    do begin step(); cyc++; end while (digit !== d && cyc < 300);
    if (digit !== d) check("wait_digit_timeout", {28'd0, digit}, {28'd0, d});
  endtask

  task automatic write(input logic [15:0] d, input logic [3:0] p);
    dm_write = 1'b1; data_in = d; dp_in = p;
    step();
    dm_write = 1'b0;
  endtask

  // Count lit cycles (any anode) and digit0-lit cycles over a window.
  task automatic count_lit(input int len, output int any_lit, output int d0_lit);
    any_lit = 0; d0_lit = 0;
    for (int k = 0; k < len; k++) begin
      step();
      if (digit != 4'hF) any_lit++;
      if (digit[0] == 1'b0) d0_lit++;
    end
  endtask

  initial begin
    int c, a, z;
    reset_n = 1'b0; dm_write = 1'b0; data_in = '0; dp_in = '0;
    blank_lz = 1'b0; brightness = 4'hF; blink_mask = '0;
    repeat (3) step();
    check("reset_digit", {28'd0, digit}, 32'hF);
    check("reset_seg", {25'd0, seg}, 32'h7F);
    check("reset_dp", {31'd0, dp}, 32'd1);
    check("reset_fd", {31'd0, frame_done}, 32'd0);

    reset_n = 1'b1;
    wait_fd(c);
    check("first_frame_done_latency", 32'(c), 32'd128);

    // Load and commit.
    write(16'h1A2F, 4'b0000);
    wait_fd(c);
    wait_digit(4'b1110);
    check("load_digit0_F", {25'd0, seg}, {25'd0, 7'b0111000});
    wait_digit(4'b0111);
    check("load_digit3_1", {25'd0, seg}, {25'd0, 7'b1001111});

    // Tear-free update written mid-frame.
    wait_digit(4'b1101);
    write(16'h4321, 4'b0000);
    wait_digit(4'b0111);
    check("tear_old_digit3", {25'd0, seg}, {25'd0, 7'b1001111});
    wait_fd(c);
    wait_digit(4'b1110);
    check("tear_new_digit0", {25'd0, seg}, {25'd0, 7'b1001111});
    wait_digit(4'b0111);
    check("tear_new_digit3", {25'd0, seg}, {25'd0, 7'b1001100});

    // Two writes in one frame: only the last is shown.
    wait_digit(4'b1110);
    write(16'h00C0, 4'b0000);
    write(16'h0007, 4'b0000);
    wait_fd(c);
    wait_digit(4'b1110);
    check("last_write_digit0", {25'd0, seg}, {25'd0, 7'b0001111});
    wait_digit(4'b1101);
    check("last_write_digit1", {25'd0, seg}, {25'd0, 7'b0000001});

    // PWM duty 4/16.
    write(16'h1A2F, 4'b0000);
    wait_fd(c);
    brightness = 4'h3;
    count_lit(128, a, z);
    check("pwm_lit_per_frame", 32'(a), 32'd32);
    check("pwm_lit_per_slot", 32'(z), 32'd8);
    brightness = 4'hF;

    // Leading-zero blanking.
    blank_lz = 1'b1;
    write(16'h0005, 4'b0000);
    wait_fd(c);
    count_lit(128, a, z);
    check("lz_0005_lit", 32'(a), 32'd32);
    wait_digit(4'b1110);
    check("lz_0005_digit0", {25'd0, seg}, {25'd0, 7'b0100100});
    write(16'h0000, 4'b0000);
    wait_fd(c);
    count_lit(128, a, z);
    check("lz_0000_lit", 32'(a), 32'd32);
    wait_digit(4'b1110);
    check("lz_0000_digit0", {25'd0, seg}, {25'd0, 7'b0000001});
    write(16'h0005, 4'b0100);
    wait_fd(c);
    count_lit(128, a, z);
    check("lz_dp_lit", 32'(a), 32'd96);
    wait_digit(4'b1011);
    check("lz_dp_digit2_dp", {31'd0, dp}, 32'd0);
    check("lz_dp_digit2_seg", {25'd0, seg}, {25'd0, 7'b0000001});
    blank_lz = 1'b0;

    // Blink digit0: lit only in phase 0.
    write(16'h1A2F, 4'b0000);
    wait_fd(c);
    blink_mask = 4'b0001;
    count_lit(512, a, z);
    check("blink_digit0_lit", 32'(z), 32'd64);
    blink_mask = 4'b0000;

    // Asynchronous reset mid-slot.
    wait_digit(4'b1101);
    step();
    reset_n = 1'b0;
    #1;
    check("async_reset_digit", {28'd0, digit}, 32'hF);
    check("async_reset_seg", {25'd0, seg}, 32'h7F);
    step();
    reset_n = 1'b1;
    wait_fd(c);
    check("restart_frame_latency", 32'(c), 32'd128);
    wait_digit(4'b1110);
    check("restart_display_zero", {25'd0, seg}, {25'd0, 7'b0000001});

    repeat (4) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
